calc_seq: RTL
=============

CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port clr  input  1  synchronous user clear; lower priority than rst.
REQ-004 SHALL have port digit_valid  input  1  a 4-bit operand is presented this cycle.
REQ-005 SHALL have port digit  input  4  operand value, unsigned.
REQ-006 SHALL have port op_valid  input  1  an operation code is presented this cycle.
REQ-007 SHALL have port op  input  2  00 SUB, 01 ADD, 10 OR, 11 NEG (unary two's complement).
REQ-008 SHALL have port alu_i1  output  4  operand A to the external ALU.
REQ-009 SHALL have port alu_i2  output  4  operand B to the external ALU.
REQ-010 SHALL have port alu_ctrl  output  2  operation code to the external ALU.
REQ-011 SHALL have port alu_res  input  4  raw 4-bit ALU result.
REQ-012 SHALL have port alu_seg  input  7  ALU seven-segment code for the result.
REQ-013 SHALL have port seg  output  7  latched display code.
REQ-014 SHALL have port busy  output  1  high in EXEC only.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a result is latched.

Function
REQ-016 SHALL implement states S_A, S_OP, S_B, S_EXEC, S_SHOW.
REQ-017 S_A: digit_valid -> alu_i1<=digit, alu_i2<=0, next S_OP; op_valid ignored.
REQ-018 S_OP: op_valid -> alu_ctrl<=op; op 11 -> S_EXEC, otherwise -> S_B; digit_valid ignored.
REQ-019 S_B: digit_valid -> alu_i2<=digit, next S_EXEC; op_valid ignored.
REQ-020 S_EXEC: exactly one cycle, operands and ctrl held stable; seg<=alu_seg, result register<=alu_res, done<=1 on exit; next S_SHOW.
REQ-021 Latency: done asserts on the second edge after the final operand (or NEG op) is accepted.
REQ-022 S_SHOW: seg held; digit_valid starts a new calculation (alu_i1<=digit, alu_i2<=0, -> S_OP); seg unchanged until the next result.
REQ-023 digit_valid and op_valid in the same cycle: only the input meaningful in the current state is consumed; the other is dropped.
REQ-024 In NEG, alu_i2 SHALL stay 0.
REQ-025 clr in any state -> S_A, alu_i1/alu_i2/alu_ctrl cleared, seg retained, done 0, inputs that cycle dropped.
REQ-026 Inputs in S_EXEC SHALL be ignored (no buffering).
REQ-027 All arithmetic is performed by the external ALU; the block only sequences operands and captures results; 4-bit wrap belongs to the ALU.

Reset
REQ-028 rst SHALL force S_A, alu_i1=0, alu_i2=0, alu_ctrl=00, seg=0000000, busy=0, done=0, result register=0, on the next edge regardless of state.
REQ-029 rst mid-operation (S_OP/S_B/S_EXEC) SHALL abandon the calculation with no done pulse.

Configuration
REQ-030 Macro CALC_ACCUM_EN SHALL enable chaining: in S_SHOW, op_valid -> alu_i1<=result register, alu_ctrl<=op, next S_EXEC (op 11) or S_B.
REQ-031 Without CALC_ACCUM_EN, op_valid in S_SHOW SHALL be ignored.
REQ-032 With CALC_ACCUM_EN, digit_valid and op_valid together in S_SHOW: op_valid wins.

Structure
REQ-033 Package calc_pkg SHALL hold the state encoding and the op constants OP_SUB, OP_ADD, OP_OR, OP_NEG.
REQ-034 No sub-module: a single FSM plus operand/result registers; the ALU stays external.

Verification
REQ-035 digit 5, op ADD, digit 3 -> alu_i1=5, alu_i2=3, alu_ctrl=01 during EXEC; done one cycle; seg=alu_seg for 8.
REQ-036 digit 4, op NEG -> S_B skipped, alu_i2=0, alu_ctrl=11; done two edges after op accepted.
REQ-037 rst asserted in S_B after digit 2, op SUB -> S_A, all outputs at reset values, no done.
REQ-038 Same-cycle digit 7 and op ADD in S_OP -> ctrl=01, digit dropped, state S_B.
REQ-039 With CALC_ACCUM_EN: 2+3, then op ADD, digit 4 in S_SHOW -> alu_i1=5, alu_i2=4; without the macro, op ignored and state stays S_SHOW.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg -- shared definitions for the calc_seq operand sequencer.
//
// Contents:
//   state_t               sequencer states (S_A, S_OP, S_B, S_EXEC, S_SHOW)
//   OP_SUB/OP_ADD/OP_OR/OP_NEG  operation codes driven to the external ALU
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,  // waiting for operand A
    S_OP   = 3'd1,  // waiting for the operation code
    S_B    = 3'd2,  // waiting for operand B
    S_EXEC = 3'd3,  // ALU settles for one cycle, result captured on exit
    S_SHOW = 3'd4   // result displayed, ready for the next calculation
  } state_t;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;  // unary: operand B is forced to 0

  // NEG needs no second operand, so it goes straight to execution.
  function automatic state_t after_op(input logic [1:0] op);
    return (op == OP_NEG) ? S_EXEC : S_B;
  endfunction

endpackage

// File: rtl/calc_seq.sv
// ---------------------------------------------------------------------------
// calc_seq -- sequences operands and an operation code into an external
// 4-bit ALU, then latches the ALU's result and seven-segment code.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   clr          synchronous user clear (keeps the displayed code)
//   digit_valid  digit carries an operand this cycle
//   digit[3:0]   unsigned operand
//   op_valid     op carries an operation code this cycle
//   op[1:0]      00 SUB, 01 ADD, 10 OR, 11 NEG
//   alu_i1[3:0]  operand A to the ALU
//   alu_i2[3:0]  operand B to the ALU
//   alu_ctrl[1:0] operation code to the ALU
//   alu_res[3:0] raw ALU result
//   alu_seg[6:0] ALU seven-segment code for alu_res
//   seg[6:0]     latched display code
//   busy         high while in S_EXEC
//   done         one-cycle pulse when a result is latched
//
// Build option:
//   CALC_ACCUM_EN  when defined, op_valid in S_SHOW chains a new operation
//                  onto the previous result (op_valid beats digit_valid).
// ---------------------------------------------------------------------------
module calc_seq
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       op_valid,
  input  logic [1:0] op,
  output logic [3:0] alu_i1,
  output logic [3:0] alu_i2,
  output logic [1:0] alu_ctrl,
  input  logic [3:0] alu_res,
  input  logic [6:0] alu_seg,
  output logic [6:0] seg,
  output logic       busy,
  output logic       done
);

  state_t     r_state;
  logic [3:0] r_i1;
  logic [3:0] r_i2;
  logic [1:0] r_ctrl;
  logic [3:0] r_result;
  logic [6:0] r_seg;
  logic       r_busy;
  logic       r_done;

  // Chaining request in S_SHOW; tied off when the feature is not built.
  logic       w_chain;

`ifdef CALC_ACCUM_EN
  assign w_chain = op_valid;
`else
  assign w_chain = 1'b0;
`endif

  // NOTE: reset is synchronous, so it is just the first branch inside the
  // clocked block; there is no reset term in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_A;
      r_i1     <= '0;
      r_i2     <= '0;
      r_ctrl   <= OP_SUB;
      r_result <= '0;
      r_seg    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (clr) begin
      // Display code and last result survive a user clear.
      r_state <= S_A;
      r_i1    <= '0;
      r_i2    <= '0;
      r_ctrl  <= OP_SUB;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge values regardless of statement order.
      r_done <= 1'b0;
      r_busy <= 1'b0;
      case (r_state)
        S_A: begin
          if (digit_valid) begin
            r_i1    <= digit;
            r_i2    <= '0;
            r_state <= S_OP;
          end
        end

        S_OP: begin
          if (op_valid) begin
            r_ctrl  <= op;
            r_state <= after_op(op);
            r_busy  <= (op == OP_NEG);
          end
        end

        S_B: begin
          if (digit_valid) begin
            r_i2    <= digit;
            r_state <= S_EXEC;
            r_busy  <= 1'b1;
          end
        end

        S_EXEC: begin
          // Operands were held stable for this cycle; the ALU outputs are
          // settled and captured as we leave.
          r_seg    <= alu_seg;
          r_result <= alu_res;
          r_done   <= 1'b1;
          r_state  <= S_SHOW;
        end

        S_SHOW: begin
          if (w_chain) begin
            // Previous result becomes operand A; B restarts at 0 so a NEG
            // chain still presents a zero second operand.
            r_i1    <= r_result;
            r_i2    <= '0;
            r_ctrl  <= op;
            r_state <= after_op(op);
            r_busy  <= (op == OP_NEG);
          end else if (digit_valid) begin
            r_i1    <= digit;
            r_i2    <= '0;
            r_state <= S_OP;
          end
        end

        default: r_state <= S_A;
      endcase
    end
  end

  assign alu_i1   = r_i1;
  assign alu_i2   = r_i2;
  assign alu_ctrl = r_ctrl;
  assign seg      = r_seg;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
